// File: rtl/pipelined_booth_mult_if.sv
// pipelined_booth_mult_if -- operand/product handshake bundle for pipelined_booth_mult.
//
// Signals:
//   in_valid  : producer offers an operand pair
//   in_ready  : multiplier accepts the offered pair this cycle
//   X, Y      : multiplicand / multiplier, WIDTH bits
//   is_signed : 1 = two's-complement operands, 0 = unsigned (travels with X/Y)
//   out_valid : P holds a product
//   out_ready : consumer takes P this cycle
//   P         : product, 2*WIDTH bits
//
// Modports: master = operand producer and product consumer, slave = multiplier.
interface pipelined_booth_mult_if #(
  parameter int WIDTH = 12
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     X;
  logic [WIDTH-1:0]     Y;
  logic                 is_signed;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   P;

  modport master (
    output in_valid, X, Y, is_signed, out_ready,
    input  in_ready, out_valid, P
  );

  modport slave (
    input  in_valid, X, Y, is_signed, out_ready,
    output in_ready, out_valid, P
  );
endinterface

// File: rtl/pipelined_booth_mult.sv
// pipelined_booth_mult -- three-stage radix-4 Booth multiplier with valid/ready flow control.
//
//   S1: Booth recoding of Y into WIDTH/2+1 partial products of X (2*WIDTH bits each)
//   S2: carry-save reduction of the partial products to a sum and a carry vector
//   S3: carry-propagate add into P
//
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset, clears every stage and P
//   bus      : pipelined_booth_mult_if.slave (operand handshake in, product handshake out)
//   done_cnt : completed-product counter, CNT_W bits, wraps
//              (only when PIPELINED_BOOTH_MULT_CNT_EN is defined)
//
// Parameters: WIDTH (even, 4..32) operand width; CNT_W width of done_cnt.
// Optional feature macro: PIPELINED_BOOTH_MULT_CNT_EN.
module pipelined_booth_mult #(
  parameter int WIDTH = 12,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  pipelined_booth_mult_if.slave  bus
`ifdef PIPELINED_BOOTH_MULT_CNT_EN
  ,
  output logic [CNT_W-1:0]       done_cnt
`endif
);

  localparam int PW   = 2 * WIDTH;
  localparam int ROWS = WIDTH / 2 + 1;

  if ((WIDTH % 2) != 0 || WIDTH < 4 || WIDTH > 32) begin : g_bad_width
    $error("pipelined_booth_mult: WIDTH must be even and in 4..32");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("pipelined_booth_mult: CNT_W must be at least 1");
  end

  // Stage valid bits and handshake.
  logic v1, v2, v3;
  logic adv1, adv2, adv3;
  logic accept;

  // A stage may load when it is empty or its contents move on this edge.
  assign adv3         = !v3 || bus.out_ready;
  assign adv2         = !v2 || adv3;
  assign adv1         = !v1 || adv2;
  assign bus.in_ready = adv1;
  assign accept       = bus.in_valid && adv1;

  // S1 combinational: Booth recoding.
  // One extra magnitude row (ROWS = WIDTH/2+1) covers unsigned operands with
  // the MSB set; for signed operands the top triplet is all sign bits and
  // recodes to zero.
  logic [WIDTH+2:0] y_pad;      // {extended Y, implicit y[-1] = 0}
  logic [PW-1:0]    x_ext;
  logic [2:0]       trip;
  logic [PW-1:0]    mag;
  logic [PW-1:0]    pp_d [ROWS];

  // NOTE: every variable written here is assigned before any branch reads or
  // skips it, so no latches are inferred.
  always_comb begin
    y_pad = bus.is_signed ? {{2{bus.Y[WIDTH-1]}}, bus.Y, 1'b0}
                          : {2'b00, bus.Y, 1'b0};
    x_ext = bus.is_signed ? {{WIDTH{bus.X[WIDTH-1]}}, bus.X}
                          : {{WIDTH{1'b0}}, bus.X};
    trip  = '0;
    mag   = '0;
    for (int i = 0; i < ROWS; i++) begin
      trip = y_pad[2*i +: 3];
      unique case (trip)
        3'b001, 3'b010: mag = x_ext;
        3'b011:         mag = x_ext << 1;
        3'b100:         mag = -(x_ext << 1);
        3'b101, 3'b110: mag = -x_ext;
        default:        mag = '0;             // 000, 111
      endcase
      pp_d[i] = mag << (2 * i);
    end
  end

  // S2 combinational: 3:2 carry-save compression, one row at a time.
  logic [PW-1:0] pp1 [ROWS];
  logic [PW-1:0] s_acc, c_acc, s_nxt;

  // NOTE: blocking assignments are deliberate here; each loop iteration must
  // see the accumulator values produced by the previous iteration.
  always_comb begin
    s_acc = pp1[0];
    c_acc = '0;
    s_nxt = '0;
    for (int i = 1; i < ROWS; i++) begin
      s_nxt = s_acc ^ c_acc ^ pp1[i];
      c_acc = ((s_acc & c_acc) | (s_acc & pp1[i]) | (c_acc & pp1[i])) << 1;
      s_acc = s_nxt;
    end
  end

  logic [PW-1:0] sum2, carry2;
  logic [PW-1:0] p_q;

  assign bus.out_valid = v3;
  assign bus.P         = p_q;

  // NOTE: the partial-product array is cleared on reset along with the rest
  // of the datapath, so no state from before reset can surface afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1     <= 1'b0;
      v2     <= 1'b0;
      v3     <= 1'b0;
      for (int i = 0; i < ROWS; i++) pp1[i] <= '0;
      sum2   <= '0;
      carry2 <= '0;
      p_q    <= '0;
`ifdef PIPELINED_BOOTH_MULT_CNT_EN
      done_cnt <= '0;
`endif
    end else begin
      if (adv1) begin
        v1 <= accept;
        if (accept) begin
          for (int i = 0; i < ROWS; i++) pp1[i] <= pp_d[i];
        end
      end
      if (adv2) begin
        v2 <= v1;
        if (v1) begin
          sum2   <= s_acc;
          carry2 <= c_acc;
        end
      end
      // P only changes when a new product arrives; it holds through stalls.
      if (adv3) begin
        v3 <= v2;
        if (v2) p_q <= sum2 + carry2;
      end
`ifdef PIPELINED_BOOTH_MULT_CNT_EN
      if (v3 && bus.out_ready) done_cnt <= done_cnt + 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_pipelined_booth_mult.sv
// tb_pipelined_booth_mult -- scoreboard bench for pipelined_booth_mult (WIDTH=12, CNT_W=4).
// Stimulus pushes the hand-computed product when a pair is accepted; an
// independent monitor pops and compares on every out_valid && out_ready.
module tb_pipelined_booth_mult;

  localparam int WIDTH = 12;
  localparam int PW    = 2 * WIDTH;

  typedef struct packed {
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             s;
    logic [PW-1:0]    p;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipelined_booth_mult_if #(.WIDTH(WIDTH)) bus ();

`ifdef PIPELINED_BOOTH_MULT_CNT_EN
  logic [3:0] done_cnt;
`endif

  pipelined_booth_mult #(.WIDTH(WIDTH), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef PIPELINED_BOOTH_MULT_CNT_EN
    ,
    .done_cnt (done_cnt)
`endif
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int n_pop  = 0;
  int n_acc  = 0;
  int n_wait = 0;
  int cyc    = 0;
  logic [PW-1:0] exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: compares every retired product against the scoreboard head.
  always @(negedge clk) begin
    cyc++;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_product: got P=0x%0h, required no product (t=%0t)", bus.P, $time);
      end else begin
        check("product", bus.P, exp_q.pop_front());
      end
      n_pop++;
    end
  end

  // Offer one pair, push its expected product when accepted, return at posedge+1.
  task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                      input logic s, input logic [PW-1:0] p);
    bus.in_valid  = 1'b1;
    bus.X         = x;
    bus.Y         = y;
    bus.is_signed = s;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back(p);
        n_acc++;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        return;
      end
      n_wait++;
    end
    check("send_accept_timeout", bus.in_ready, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      if (exp_q.size() == 0) break;
    end
    #1;
    check("drain_empty", exp_q.size(), 0);
  endtask

  vec_t dir_vecs [10] = '{
    '{12'hFFF, 12'hFFF, 1'b0, 24'hFFE001},
    '{12'h800, 12'h800, 1'b1, 24'h400000},
    '{12'h800, 12'h7FF, 1'b1, 24'hC00800},
    '{12'hFFF, 12'h001, 1'b1, 24'hFFFFFF},
    '{12'hFFF, 12'hFFF, 1'b1, 24'h000001},
    '{12'h7FF, 12'h7FF, 1'b1, 24'h3FF001},
    '{12'hFFE, 12'h003, 1'b1, 24'hFFFFFA},
    '{12'h800, 12'h7FF, 1'b0, 24'h3FF800},
    '{12'hFFE, 12'h003, 1'b0, 24'h002FFA},
    '{12'h123, 12'h456, 1'b0, 24'h04EDC2}
  };

  logic [PW-1:0] stream_exp [8] = '{24'd0, 24'd2, 24'd6, 24'd12, 24'd20, 24'd30, 24'd42, 24'd56};

  vec_t stall_vecs [5] = '{
    '{12'h003, 12'h005, 1'b0, 24'h00000F},
    '{12'h007, 12'h009, 1'b0, 24'h00003F},
    '{12'h00A, 12'h00A, 1'b0, 24'h000064},
    '{12'h100, 12'h010, 1'b0, 24'h001000},
    '{12'hFFF, 12'h002, 1'b0, 24'h001FFE}
  };

  initial begin
    int w0, p0, a0, c0, c1;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.X         = '0;
    bus.Y         = '0;
    bus.is_signed = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_p", bus.P, 0);
    check("rst_in_ready", bus.in_ready, 1);
`ifdef PIPELINED_BOOTH_MULT_CNT_EN
    check("rst_done_cnt", done_cnt, 0);
`endif
    rst = 1'b0;

    // Latency: accepting edge is the first of three register edges.
    send(12'hFFF, 12'hFFF, 1'b0, 24'hFFE001);
    check("lat_after_edge1", bus.out_valid, 0);
    @(posedge clk); #1;
    check("lat_after_edge2", bus.out_valid, 0);
    @(posedge clk); #1;
    check("lat_after_edge3", bus.out_valid, 1);
    check("lat_p", bus.P, 24'hFFE001);
    drain();

    // Directed signed / unsigned vectors.
    foreach (dir_vecs[i]) send(dir_vecs[i].x, dir_vecs[i].y, dir_vecs[i].s, dir_vecs[i].p);
    drain();

    // Back-to-back stream, out_ready held high.
    w0 = n_wait;
    p0 = n_pop;
    c0 = 0;
    c1 = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(WIDTH'(i), WIDTH'(i + 1), 1'b0, stream_exp[i]);
      end
      begin
        for (int k = 0; k < 50; k++) begin
          @(posedge clk);
          if (n_pop > p0) break;
        end
        c0 = cyc;
        for (int k = 0; k < 50; k++) begin
          @(posedge clk);
          if (n_pop >= p0 + 8) break;
        end
        c1 = cyc;
      end
    join
    check("stream_in_ready_stalls", n_wait - w0, 0);
    check("stream_consecutive", c1 - c0, 7);
    drain();
    check("stream_pops", n_pop - p0, 8);

    // Output stall from the cycle of the first out_valid.
    a0 = n_acc;
    p0 = n_pop;
    fork
      begin
        foreach (stall_vecs[i]) send(stall_vecs[i].x, stall_vecs[i].y, stall_vecs[i].s, stall_vecs[i].p);
      end
      begin
        for (int k = 0; k < 50; k++) begin
          @(posedge clk); #1;
          if (bus.out_valid) break;
        end
        bus.out_ready = 1'b0;
        repeat (5) @(negedge clk);
        check("stall_out_valid", bus.out_valid, 1);
        check("stall_in_ready", bus.in_ready, 0);
        check("stall_hold_p", bus.P, 24'h00000F);
        check("stall_accepts", n_acc - a0, 3);
        check("stall_no_pop", n_pop - p0, 0);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();
    check("stall_pops", n_pop - p0, 5);

    // Reset with two products in flight.
    send(12'h005, 12'h006, 1'b0, 24'd30);
    send(12'h007, 12'h008, 1'b0, 24'd56);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_p", bus.P, 0);
    check("midrst_in_ready", bus.in_ready, 1);
`ifdef PIPELINED_BOOTH_MULT_CNT_EN
    check("midrst_done_cnt", done_cnt, 0);
`endif
    exp_q.delete();
    @(posedge clk); #1;
    check("rst_hold_in_ready", bus.in_ready, 1);
    rst = 1'b0;

    // Resume: first pair taken on the first edge after release, no stale output.
    w0 = n_wait;
    p0 = n_pop;
    send(12'h009, 12'h00B, 1'b0, 24'h000063);
    check("resume_first_edge", n_wait - w0, 0);
    check("resume_no_stale_1", bus.out_valid, 0);
    @(posedge clk); #1;
    check("resume_no_stale_2", bus.out_valid, 0);
    for (int i = 0; i < 16; i++) send(WIDTH'(i + 1), 12'h003, 1'b0, PW'(3 * (i + 1)));
    drain();
    check("resume_pops", n_pop - p0, 17);
`ifdef PIPELINED_BOOTH_MULT_CNT_EN
    check("done_cnt_wrap", done_cnt, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, required summary before %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
